// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register file and its scheduler.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    // 32 register-file entries
    typedef logic [4:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // Scheduler sequencing: one clearing cycle, then normal operation
    typedef enum logic {
        StClear,
        StRun
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request found scanning upward from i_rr_ptr with wrap.
module rr_arbiter #(
    parameter int unsigned N    = 2,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [PtrW-1:0] i_rr_ptr,
    output logic [N-1:0]    o_gnt
);

    logic            w_found;
    logic [PtrW-1:0] w_idx;

    // One-hot grant to the first active request at or after the priority pointer
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = PtrW'((32'(i_rr_ptr) + off) % N);
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Write-port arbiter and circular-FIFO pointer sequencer in front of instr_register.
module instr_reg_scheduler
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 32,
    localparam int unsigned CntW    = $clog2(DEPTH) + 1,
    localparam int unsigned RrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NUM_REQ-1:0]  i_req_valid,
    output logic [NUM_REQ-1:0]  o_req_ready,
    input  opcode_t             i_req_opcode    [NUM_REQ],
    input  operand_t            i_req_operand_a [NUM_REQ],
    input  operand_t            i_req_operand_b [NUM_REQ],
    input  logic                i_flush,
    output logic                o_rd_valid,
    input  logic                i_rd_ready,
    output instruction_t        o_rd_instr,
    output logic [CntW-1:0]     o_count,
    output logic                o_ir_load_en,
    output logic                o_ir_reset_n,
    output opcode_t             o_ir_opcode,
    output operand_t            o_ir_operand_a,
    output operand_t            o_ir_operand_b,
    output address_t            o_ir_write_pointer,
    output address_t            o_ir_read_pointer,
    input  instruction_t        i_ir_instruction_word
);

    sched_state_t       r_state, w_state_next;
    address_t           r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]    r_count;
    logic [RrW-1:0]     r_rr_ptr, w_rr_next;

    logic               w_run, w_full, w_empty, w_can_grant;
    logic               w_push, w_pop, w_clr;
    logic [NUM_REQ-1:0] w_req, w_gnt;

    assign w_run   = (r_state == StRun);
    assign w_full  = (r_count == CntW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Reset or flush in the current cycle drops any grant so nothing is written
    assign w_can_grant = w_run & ~i_reset & ~i_flush & ~w_full;
    assign w_req       = i_req_valid & {NUM_REQ{w_can_grant}};

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_gnt)
    );

    assign o_req_ready        = w_gnt;
    assign w_push             = |(i_req_valid & w_gnt);
    assign w_pop              = w_run & ~w_empty & i_rd_ready;
    assign o_rd_valid         = w_run & ~w_empty;
    assign o_rd_instr         = i_ir_instruction_word;
    assign o_count            = r_count;
    assign o_ir_load_en       = w_push;
    assign o_ir_reset_n       = w_run;
    assign o_ir_write_pointer = r_wr_ptr;
    assign o_ir_read_pointer  = r_rd_ptr;

    // Pointers/count return to zero on reset, during CLEAR, and on a flush edge
    assign w_clr = i_reset | ~w_run | i_flush;

    // Route the granted requester to the register write port; next RR pointer follows it
    always_comb begin
        o_ir_opcode    = ZERO;
        o_ir_operand_a = '0;
        o_ir_operand_b = '0;
        w_rr_next      = r_rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                o_ir_opcode    = i_req_opcode[i];
                o_ir_operand_a = i_req_operand_a[i];
                o_ir_operand_b = i_req_operand_b[i];
                w_rr_next      = RrW'((i + 1) % NUM_REQ);
            end
        end
    end

    // Next state: CLEAR lasts exactly one cycle; flush sends RUN back to CLEAR
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: w_state_next = StRun;
            StRun:   if (i_flush) w_state_next = StClear;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StClear;
        else         r_state <= w_state_next;
    end

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Randomised directed bench for instr_reg_scheduler against a queue-based FIFO model.
module tb_instr_reg_scheduler;
    import instr_register_pkg::*;

    localparam int NREQ = 2;
    localparam int DEP  = 32;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    opcode_t         req_opc [NREQ];
    operand_t        req_a   [NREQ];
    operand_t        req_b   [NREQ];
    logic            flush;
    logic            rd_valid;
    logic            rd_ready;
    instruction_t    rd_instr;
    logic [5:0]      count;
    logic            ir_load_en;
    logic            ir_reset_n;
    opcode_t         ir_opc;
    operand_t        ir_a, ir_b;
    address_t        ir_wp, ir_rp;
    instruction_t    ir_word;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: an ordered queue of accepted instructions
    bit           m_clear;
    instruction_t m_q[$];
    int           m_wr;
    int           m_rr;
    int           m_last_g;
    bit           rand_opc;

    // Register-file stand-in for instr_register
    instruction_t mem [DEP];

    instr_reg_scheduler #(
        .NUM_REQ (NREQ),
        .DEPTH   (DEP)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_req_valid           (req_valid),
        .o_req_ready           (req_ready),
        .i_req_opcode          (req_opc),
        .i_req_operand_a       (req_a),
        .i_req_operand_b       (req_b),
        .i_flush               (flush),
        .o_rd_valid            (rd_valid),
        .i_rd_ready            (rd_ready),
        .o_rd_instr            (rd_instr),
        .o_count               (count),
        .o_ir_load_en          (ir_load_en),
        .o_ir_reset_n          (ir_reset_n),
        .o_ir_opcode           (ir_opc),
        .o_ir_operand_a        (ir_a),
        .o_ir_operand_b        (ir_b),
        .o_ir_write_pointer    (ir_wp),
        .o_ir_read_pointer     (ir_rp),
        .i_ir_instruction_word (ir_word)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ir_load_en) mem[ir_wp] <= '{opc: ir_opc, op_a: ir_a, op_b: ir_b};
    end

    assign ir_word = mem[ir_rp];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        assert (act === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic refresh(input int i);
        req_a[i] = operand_t'($urandom);
        req_b[i] = operand_t'($urandom);
        if (rand_opc) req_opc[i] = opcode_t'($urandom_range(0, 7));
    endtask

    // One clock cycle: drive, check against the model, advance the model at the edge
    task automatic step(input logic [NREQ-1:0] v, input logic pop, input logic fl,
                        input logic rst);
        int g;
        int sz;
        int rp;
        logic [NREQ-1:0] exp_rdy;
        req_valid = v;
        rd_ready  = pop;
        flush     = fl;
        reset     = rst;
        #3;
        sz = m_q.size();
        rp = (m_wr - sz + DEP) % DEP;
        g  = -1;
        if (m_clear) begin
            chk("clr_ready", 128'(req_ready), 128'(0));
            chk("clr_rd_valid", 128'(rd_valid), 128'(0));
            chk("clr_load_en", 128'(ir_load_en), 128'(0));
            chk("clr_reset_n", 128'(ir_reset_n), 128'(0));
            chk("clr_wr_ptr", 128'(ir_wp), 128'(0));
            chk("clr_rd_ptr", 128'(ir_rp), 128'(0));
            chk("clr_count", 128'(count), 128'(0));
        end else begin
            if (!fl && !rst && sz < DEP) begin
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (m_rr + k) % NREQ;
                    if (g < 0 && v[c]) g = c;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("ready", 128'(req_ready), 128'(exp_rdy));
            chk("load_en", 128'(ir_load_en), 128'(g >= 0));
            chk("reset_n", 128'(ir_reset_n), 128'(1));
            chk("wr_ptr", 128'(ir_wp), 128'(m_wr));
            chk("rd_ptr", 128'(ir_rp), 128'(rp));
            chk("count", 128'(count), 128'(sz));
            chk("rd_valid", 128'(rd_valid), 128'(sz != 0));
            if (sz != 0) chk("rd_instr", 128'(rd_instr), 128'(m_q[0]));
            if (g >= 0) begin
                chk("ir_opcode", 128'(ir_opc), 128'(req_opc[g]));
                chk("ir_operand_a", 128'(ir_a), 128'(req_a[g]));
                chk("ir_operand_b", 128'(ir_b), 128'(req_b[g]));
            end
        end
        m_last_g = g;
        @(posedge clk);
        if (rst) begin
            m_clear = 1;
            m_q.delete();
            m_wr = 0;
        end else if (m_clear) begin
            m_clear = 0;
            m_q.delete();
            m_wr = 0;
            m_rr = 0;
        end else if (fl) begin
            m_clear = 1;
            m_q.delete();
            m_wr = 0;
        end else begin
            if (pop && sz > 0) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back('{opc: req_opc[g], op_a: req_a[g], op_b: req_b[g]});
                m_wr = (m_wr + 1) % DEP;
                m_rr = (g + 1) % NREQ;
            end
        end
        #1;
        if (g >= 0) refresh(g);
    endtask

    logic [NREQ-1:0] cur_v;

    initial begin
        clk       = 0;
        reset     = 1;
        req_valid = '0;
        rd_ready  = 0;
        flush     = 0;
        rand_opc  = 0;
        for (int i = 0; i < NREQ; i++) refresh(i);
        req_opc[0] = ADD;
        req_opc[1] = SUB;
        repeat (2) @(posedge clk);
        #1;
        reset   = 0;
        m_clear = 1;
        m_q.delete();
        m_wr    = 0;
        m_rr    = 0;

        // Reset release: one CLEAR cycle then idle RUN
        step(2'b00, 0, 0, 0);
        step(2'b00, 0, 0, 0);

        // Both requesters continuously: ADD/SUB alternate
        repeat (6) step(2'b11, 0, 0, 0);

        // Drain, plus one pop attempt on empty
        repeat (7) step(2'b00, 1, 0, 0);

        // Fill to full from a clean start, then request+pop while full, then wrap write
        step(2'b00, 0, 1, 0);
        step(2'b00, 0, 0, 0);
        repeat (DEP) step(2'b11, 0, 0, 0);
        step(2'b11, 1, 0, 0);
        step(2'b11, 0, 0, 0);

        // Simultaneous push and pop at count 5
        step(2'b00, 0, 1, 0);
        step(2'b00, 0, 0, 0);
        repeat (5) step(2'b01, 0, 0, 0);
        step(2'b10, 1, 0, 0);
        step(2'b00, 0, 0, 0);

        // Random traffic; a waiting requester keeps its request and data
        rand_opc = 1;
        cur_v    = '0;
        repeat (80) begin
            for (int i = 0; i < NREQ; i++) if (!cur_v[i]) cur_v[i] = 1'($urandom_range(0, 1));
            step(cur_v, 1'($urandom_range(0, 1)), 0, 0);
            if (m_last_g >= 0) cur_v[m_last_g] = 1'b0;
        end

        // Flush with 10 entries while requesting
        step(2'b00, 0, 1, 0);
        step(2'b00, 0, 0, 0);
        repeat (10) step(2'b11, 0, 0, 0);
        step(2'b11, 0, 1, 0);
        step(2'b11, 0, 0, 0);
        step(2'b11, 0, 0, 0);
        step(2'b11, 1, 0, 0);

        // Synchronous reset mid-operation
        repeat (3) step(2'b11, 1, 0, 0);
        step(2'b11, 0, 0, 1);
        step(2'b00, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b00, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
